// File: rtl/ibex_rvc_realign_decoder.sv
// Halfword realignment FIFO plus RV32C expander between the fetch port and ID.
// Optional retired-compressed counter is enabled by defining IBEX_RVC_STATS_EN.
module ibex_rvc_realign_decoder #(
  parameter int unsigned DEPTH     = 6,
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0080
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fetch_valid_i,
  output logic        fetch_ready_o,
  input  logic [31:0] fetch_rdata_i,
  input  logic        fetch_err_i,
  input  logic        flush_i,
  input  logic [31:0] flush_addr_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_raw_o,
  output logic [31:0] instr_pc_o,
  output logic        instr_is_compressed_o,
  output logic        instr_illegal_o,
  output logic        instr_err_o,
  output logic [31:0] cnt_compressed_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Handshake: a transfer happens on a port in every cycle where its valid and
  // ready are both high; valid never depends on ready of the same port.

  // Entry layout: bit 16 = fetch error, bits 15:0 = halfword. Entry 0 is the head.
  logic [16:0]   mem   [DEPTH];
  logic [16:0]   mem_n [DEPTH];
  logic [16:0]   ext   [DEPTH+2];
  logic [CW-1:0] count, count_n, base;
  logic [31:0]   pc;
  logic          discard;

  logic        head_err, head_comp, single, avail, fire, push;
  logic [1:0]  pop_n;
  logic [31:0] raw32;
  logic [32:0] exp_w;
  logic        dec_ill;
  logic        unused_addr_bit;

  assign unused_addr_bit = flush_addr_i[0];

  function automatic logic [32:0] expand(input logic [15:0] c);
    logic [31:0] ins;
    logic        ill;
    logic [2:0]  f3;
    ins = {16'h0000, c};
    ill = 1'b0;
    f3  = 3'b000;
    case (c[1:0])
      2'b00: begin
        case (c[15:13])
          3'b000: begin
            ins = {2'b00, c[10:7], c[12:11], c[5], c[6], 2'b00, 5'd2, 3'b000, 2'b01, c[4:2], 7'b0010011};
            ill = (c[12:5] == 8'd0);
          end
          3'b010: ins = {5'd0, c[5], c[12:10], c[6], 2'b00, 2'b01, c[9:7], 3'b010, 2'b01, c[4:2], 7'b0000011};
          3'b110: ins = {5'd0, c[5], c[12], 2'b01, c[4:2], 2'b01, c[9:7], 3'b010, c[11:10], c[6], 2'b00, 7'b0100011};
          default: ill = 1'b1;
        endcase
      end
      2'b01: begin
        case (c[15:13])
          3'b000: ins = {{7{c[12]}}, c[6:2], c[11:7], 3'b000, c[11:7], 7'b0010011};
          3'b001, 3'b101: // c.jal links to x1, c.j to x0
            ins = {c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], c[12], {8{c[12]}},
                   4'b0000, ~c[15], 7'b1101111};
          3'b010: ins = {{7{c[12]}}, c[6:2], 5'd0, 3'b000, c[11:7], 7'b0010011};
          3'b011: begin
            ill = ({c[12], c[6:2]} == 6'd0);
            if (c[11:7] == 5'd2)
              ins = {{3{c[12]}}, c[4:3], c[5], c[2], c[6], 4'b0000, 5'd2, 3'b000, 5'd2, 7'b0010011};
            else
              ins = {{15{c[12]}}, c[6:2], c[11:7], 7'b0110111};
          end
          3'b100: begin
            case (c[11:10])
              2'b00, 2'b01: begin
                ins = {1'b0, c[10], 5'd0, c[6:2], 2'b01, c[9:7], 3'b101, 2'b01, c[9:7], 7'b0010011};
                ill = c[12];
              end
              2'b10: ins = {{7{c[12]}}, c[6:2], 2'b01, c[9:7], 3'b111, 2'b01, c[9:7], 7'b0010011};
              default: begin
                case (c[6:5])
                  2'b00:   f3 = 3'b000;
                  2'b01:   f3 = 3'b100;
                  2'b10:   f3 = 3'b110;
                  default: f3 = 3'b111;
                endcase
                ins = {1'b0, (c[6:5] == 2'b00), 5'd0, 2'b01, c[4:2], 2'b01, c[9:7], f3, 2'b01, c[9:7], 7'b0110011};
                ill = c[12];
              end
            endcase
          end
          default: // c.beqz / c.bnez, funct3 taken from c[13]
            ins = {c[12], {3{c[12]}}, c[6:5], c[2], 5'd0, 2'b01, c[9:7], 2'b00, c[13],
                   c[11:10], c[4:3], c[12], 7'b1100011};
        endcase
      end
      2'b10: begin
        case (c[15:13])
          3'b000: begin
            ins = {7'd0, c[6:2], c[11:7], 3'b001, c[11:7], 7'b0010011};
            ill = c[12];
          end
          3'b010: begin
            ins = {4'd0, c[3:2], c[12], c[6:4], 2'b00, 5'd2, 3'b010, c[11:7], 7'b0000011};
            ill = (c[11:7] == 5'd0);
          end
          3'b100: begin
            if (!c[12]) begin
              if (c[6:2] == 5'd0) begin
                ins = {12'd0, c[11:7], 3'b000, 5'd0, 7'b1100111};
                ill = (c[11:7] == 5'd0);
              end else begin
                ins = {7'd0, c[6:2], 5'd0, 3'b000, c[11:7], 7'b0110011};
              end
            end else if (c[6:2] == 5'd0) begin
              if (c[11:7] == 5'd0) ins = 32'h0010_0073;
              else                 ins = {12'd0, c[11:7], 3'b000, 5'd1, 7'b1100111};
            end else begin
              ins = {7'd0, c[6:2], c[11:7], 3'b000, c[11:7], 7'b0110011};
            end
          end
          3'b110: ins = {4'd0, c[8:7], c[12], c[6:2], 5'd2, 3'b010, c[11:9], 2'b00, 7'b0100011};
          default: ill = 1'b1;
        endcase
      end
      default: ill = 1'b0;
    endcase
    if (ill) ins = {16'h0000, c};
    return {ill, ins};
  endfunction

  assign fetch_ready_o = (DEPTH_C - count) >= CW'(2);
  assign head_err  = mem[0][16];
  assign head_comp = (mem[0][1:0] != 2'b11);
  // An erroring head is delivered alone so the bad fetch never consumes the next word.
  assign single    = head_comp | head_err;
  assign avail     = single ? (count != '0) : (count >= CW'(2));
  assign instr_valid_o = avail & ~flush_i;
  assign fire      = instr_valid_o & instr_ready_i;
  assign pop_n     = fire ? (single ? 2'd1 : 2'd2) : 2'd0;
  assign push      = fetch_valid_i & fetch_ready_o & ~flush_i;

  assign raw32   = single ? {16'h0000, mem[0][15:0]} : {mem[1][15:0], mem[0][15:0]};
  assign exp_w   = expand(mem[0][15:0]);
  assign dec_ill = head_comp & ~head_err & exp_w[32];

  assign instr_raw_o           = avail ? raw32 : 32'h0;
  assign instr_o               = avail ? ((head_comp & ~head_err & ~exp_w[32]) ? exp_w[31:0] : raw32) : 32'h0;
  assign instr_is_compressed_o = avail & head_comp;
  assign instr_illegal_o       = avail & dec_ill;
  assign instr_err_o           = avail & (head_err | (~head_comp & mem[1][16]));
  assign instr_pc_o            = pc;

  assign base = count - CW'(pop_n);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) ext[i] = mem[i];
    ext[DEPTH]   = '0;
    ext[DEPTH+1] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      mem_n[i] = (pop_n == 2'd2) ? ext[i+2] : ((pop_n == 2'd1) ? ext[i+1] : ext[i]);
      if (push) begin
        if (discard) begin
          if (CW'(i) == base) mem_n[i] = {fetch_err_i, fetch_rdata_i[31:16]};
        end else begin
          if (CW'(i) == base)          mem_n[i] = {fetch_err_i, fetch_rdata_i[15:0]};
          if (CW'(i) == base + CW'(1)) mem_n[i] = {fetch_err_i, fetch_rdata_i[31:16]};
        end
      end
    end
    count_n = base + (push ? (discard ? CW'(1) : CW'(2)) : CW'(0));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count   <= '0;
      pc      <= BOOT_ADDR;
      discard <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush_i) begin
      count   <= '0;
      pc      <= {flush_addr_i[31:1], 1'b0};
      discard <= flush_addr_i[1];
    end else begin
      count <= count_n;
      pc    <= pc + {29'd0, pop_n, 1'b0};
      for (int i = 0; i < DEPTH; i++) mem[i] <= mem_n[i];
      if (push) discard <= 1'b0;
    end
  end

`ifdef IBEX_RVC_STATS_EN
  logic [31:0] cnt;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      cnt <= '0;
    else if (fire && head_comp && !head_err && cnt != 32'hFFFF_FFFF)
      cnt <= cnt + 32'd1;
  end
  assign cnt_compressed_o = cnt;
`else
  assign cnt_compressed_o = 32'h0;
`endif

endmodule
